uart_rx_ctrl_param: RTL and testbench
=====================================

// Module: uart_rx_ctrl_param
// PURPOSE
//  Parametrised UART receive controller; successor of the fixed 8-bit RX FSM. Integrates RX synchroniser,
//  edge/bit counters, 3-sample majority voting, deserialiser and parity/stop checks. Adds configurable data
//  width, runtime prescale, odd/even parity, 1/2 stop bits and error pulses. Sits in the UART RX path between
//  the RX pad and the RX data synchroniser feeding the system controller.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame, LSB first (legal 5..9)
//  PRESC_W     6  width of Prescale input (max oversampling 32)
// PORTS
//  CLK            in   1           single clock for all logic
//  RST            in   1           synchronous reset, active-low
//  RX_IN          in   1           asynchronous serial line, idle high
//  Prescale       in   PRESC_W     oversampling ratio: 8, 16 or 32
//  PAR_EN         in   1           1 = parity bit present
//  PAR_TYP        in   1           0 = even, 1 = odd
//  STOP2          in   1           1 = two stop bits
//  P_DATA         out  DATA_WIDTH  received word, held until next valid frame
//  Data_Valid     out  1           1-cycle pulse, P_DATA updated this cycle
//  Parity_Error   out  1           1-cycle pulse at frame end on parity mismatch
//  Framing_Error  out  1           1-cycle pulse at frame end if any stop bit sampled 0
//  Busy           out  1           high while state != IDLE
// BEHAVIOUR
//  - Reset: CLK edge with RST=0 -> state IDLE, counters 0, sync flops 1, all outputs 0 (P_DATA=0).
//    Reset mid-frame aborts the frame; no pulse is emitted.
//  - RX_IN passes a 2-flop synchroniser (rx_s); all timing below refers to rx_s.
//  - Config (Prescale, PAR_EN, PAR_TYP, STOP2) is latched at start detection; mid-frame changes are ignored.
//    Prescale not in {8,16,32} is latched as 8.
//  - edge_cnt runs 0..P-1 per bit (P = latched prescale); bit end = edge_cnt==P-1, then wraps to 0.
//  - Samples taken at edge_cnt P/2-2, P/2-1, P/2; bit value = majority of 3, valid from edge P/2+1.
//  - States: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   falling edge (rx_s_q==1 && rx_s==0) -> START, that cycle is edge 0.
//            A line held low never re-triggers.
//    START:  at bit end: bit==0 -> DATA, bit_cnt=0; bit==1 (glitch) -> IDLE silently.
//    DATA:   at each bit end shift bit into shift reg (LSB first), bit_cnt++.
//            After DATA_WIDTH bits -> PARITY if PAR_EN else STOP.
//    PARITY: at bit end compare bit with ^data (even) or ~^data (odd); mismatch sets par_err.
//    STOP:   at bit end a 0 sets frm_err; after 1 (or 2 if STOP2) stop bits -> IDLE and emit results.
//  - Emission: registered, asserted in the cycle after the final stop-bit end.
//    No errors -> Data_Valid=1 and P_DATA loaded. Errors -> matching error pulse(s) only; P_DATA unchanged.
//    Data_Valid is never high together with an error.
//  - Back-to-back frames: a start edge arriving in the emission cycle or later is detected normally.
//  - Latency from RX start edge to Data_Valid:
//    2 + P*(1 + DATA_WIDTH + PAR_EN + 1 + STOP2) + 1 cycles.
// STRUCTURE
//  - Shared package uart_pkg: state localparams
//    (IDLE=3'b000, START=3'b001, DATA=3'b011, PARITY=3'b111, STOP=3'b101) and legal prescale constants.
//  - One sub-module: uart_rx_sampler (3-sample majority vote, driven by edge_cnt and latched P).
//    Sync, counters, FSM, shifter and checks live in the top.
// TESTING
//  1 P=8, no parity, 1 stop, byte 0xA5 -> Data_Valid 1 cycle, P_DATA=0xA5, exactly 2+80+1 cycles after start edge.
//  2 P=16, PAR_EN=1, PAR_TYP=1, 0x3C with wrong parity bit -> Parity_Error pulse, no Data_Valid, P_DATA keeps old value.
//  3 P=32, STOP2=1, second stop bit 0 -> Framing_Error pulse; hold RX low 100 cycles -> no new frame until rising then falling edge.
//  4 4-cycle low glitch on idle line at P=16 -> returns IDLE, no pulses, Busy high then low.
//  5 Two back-to-back frames 0x55, 0xFF at P=8 -> two Data_Valid pulses, correct P_DATA each.
//    1-sample noise spike mid-bit is rejected by majority.
//  6 RST low mid-DATA, then frame 0x81 -> first frame discarded silently, 0x81 received.
//    DATA_WIDTH=7 build receives 0x7F.

Source files
------------

// File: rtl/uart_pkg.sv
// UART RX shared definitions: FSM state encoding, legal prescale ratios, config record, vote helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Encodings are fixed so that states can be recognised on a logic analyser.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b111,
        STOP   = 3'b101
    } rx_state_e;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    // Frame options captured at start detection.
    typedef struct packed {
        logic par_en;
        logic par_typ;
        logic stop2;
    } rx_cfg_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// UART RX bit sampler: three samples around mid-bit, bit value is their majority.
// Latency: samples at edge_cnt P/2-2, P/2-1, P/2; voted bit valid from edge P/2+1 until next bit's samples.
// Backpressure: none; free-running alongside the edge counter.
// Ports: clk_i/rst_ni clock and sync active-low reset, rx_i synchronised line,
//        edge_cnt_i position inside the current bit, presc_i latched ratio P, bit_o voted bit.
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rx_i,
    input  logic [PRESC_W-1:0] edge_cnt_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               bit_o
);
    import uart_pkg::*;

    logic [PRESC_W-1:0] half;
    logic [2:0]         samp_q, samp_d;

    assign half = presc_i >> 1;

    always_comb begin
        samp_d = samp_q;
        if (edge_cnt_i == half - PRESC_W'(2)) samp_d[0] = rx_i;
        if (edge_cnt_i == half - PRESC_W'(1)) samp_d[1] = rx_i;
        if (edge_cnt_i == half)               samp_d[2] = rx_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) samp_q <= 3'b111;
        else         samp_q <= samp_d;
    end

    assign bit_o = maj3(samp_q);

endmodule

// File: rtl/uart_rx_ctrl_param.sv
// Parametrised UART receiver: 2-flop sync, oversampled bit timing, deserialiser, parity/stop checks.
// Latency: start edge to Data_Valid = 2 + P*(1 + DATA_WIDTH + PAR_EN + 1 + STOP2) + 1 cycles.
// Backpressure: none; results are single-cycle pulses, P_DATA holds the last good word.
// Ports: CLK, RST (sync active-low), RX_IN (async line, idle high), Prescale/PAR_EN/PAR_TYP/STOP2 config,
//        P_DATA word, Data_Valid / Parity_Error / Framing_Error pulses, Busy while a frame is in flight.
module uart_rx_ctrl_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Framing_Error,
    output logic                  Busy
);
    import uart_pkg::*;

    logic [1:0]            sync_q;
    logic                  rx_s, rx_s_q;
    rx_state_e             state_q, state_d;
    rx_cfg_t               cfg_q, cfg_d;
    logic [PRESC_W-1:0]    presc_q, presc_d, presc_sel;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_err_q, par_err_d, frm_err_q, frm_err_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
    logic                  bit_val, bit_end, start_det, exp_par, frm_now;

    assign rx_s      = sync_q[1];
    // Requires a high-to-low transition, so a line stuck low cannot start frames repeatedly.
    assign start_det = rx_s_q & ~rx_s;
    assign bit_end   = (edge_cnt_q == presc_q - PRESC_W'(1));
    assign exp_par   = cfg_q.par_typ ? ~^shift_q : ^shift_q;
    assign presc_sel = (Prescale == PRESC_W'(PRESC_16) || Prescale == PRESC_W'(PRESC_32))
                       ? Prescale : PRESC_W'(PRESC_8);

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .rx_i       (rx_s),
        .edge_cnt_i (edge_cnt_q),
        .presc_i    (presc_q),
        .bit_o      (bit_val)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        presc_d    = presc_q;
        edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
        frm_now    = frm_err_q | ~bit_val;

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                if (start_det) begin
                    // The detection cycle is edge 0 of the start bit.
                    state_d    = START;
                    edge_cnt_d = PRESC_W'(1);
                    presc_d    = presc_sel;
                    cfg_d      = {PAR_EN, PAR_TYP, STOP2};
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            START: if (bit_end) begin
                if (!bit_val) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;        // glitch: drop silently
                end
            end
            DATA: if (bit_end) begin
                shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                    state_d    = cfg_q.par_en ? PARITY : STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            PARITY: if (bit_end) begin
                if (bit_val != exp_par) par_err_d = 1'b1;
                state_d    = STOP;
                stop_cnt_d = 1'b0;
            end
            STOP: if (bit_end) begin
                frm_err_d = frm_now;
                if (stop_cnt_q == cfg_q.stop2) begin
                    state_d = IDLE;
                    pe_d    = par_err_q;
                    fe_d    = frm_now;
                    if (!frm_now && !par_err_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q     <= 2'b11;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            cfg_q      <= '0;
            presc_q    <= PRESC_W'(PRESC_8);
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], RX_IN};
            rx_s_q     <= rx_s;
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            presc_q    <= presc_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
        end
    end

    assign P_DATA        = p_data_q;
    assign Data_Valid    = dv_q;
    assign Parity_Error  = pe_q;
    assign Framing_Error = fe_q;
    assign Busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// Bench for uart_rx_ctrl_param: table of frames plus corner sequences, scoreboard of expected pulses.
// Latency: measured per good frame against 2 + P*bits + 1.
// Backpressure: n/a.
module tb_uart_rx_ctrl_param;

    typedef struct {
        logic [5:0] presc;     // value put on the Prescale bus
        int         p;         // bit length the sender actually uses
        logic       par_en;
        logic       par_typ;
        logic       stop2;
        logic [7:0] data;
        logic       par_flip;  // send the wrong parity bit
        int         stop_bad;  // 0 none, 1 first stop low, 2 second stop low
        logic       exp_dv;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       fe;
        logic [7:0] pd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx7 = 1'b1;
    logic [5:0] presc = 6'd8;
    logic       par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
    logic [7:0] p_data;
    logic       dv, pe, fe, busy;
    logic [6:0] p_data7;
    logic       dv7, pe7, fe7, busy7;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_dv_cyc = 0;
    int   start_cyc = 0;
    int   dv7_cnt = 0;
    int   err7_cnt = 0;
    logic [6:0] last_p7 = '0;
    logic busy_seen = 1'b0;
    logic [7:0] last_good = 8'h00;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    uart_rx_ctrl_param #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .Prescale(presc),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .P_DATA(p_data), .Data_Valid(dv), .Parity_Error(pe), .Framing_Error(fe), .Busy(busy)
    );

    uart_rx_ctrl_param #(.DATA_WIDTH(7), .PRESC_W(6)) dut7 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx7), .Prescale(presc),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
        .P_DATA(p_data7), .Data_Valid(dv7), .Parity_Error(pe7), .Framing_Error(fe7), .Busy(busy7)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (dv || pe || fe) begin
            if (dv) last_dv_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: dv=%b pe=%b fe=%b p_data=0x%0h, none expected", dv, pe, fe, p_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_valid", 32'(dv), 32'(mon_e.dv));
                check("parity_error", 32'(pe), 32'(mon_e.pe));
                check("framing_error", 32'(fe), 32'(mon_e.fe));
                check("p_data", 32'(p_data), 32'(mon_e.pd));
            end
        end
        if (dv7) begin
            dv7_cnt++;
            last_p7 = p_data7;
        end
        if (pe7 || fe7) err7_cnt++;
    end

    task automatic push_exp(input logic edv, input logic epe, input logic efe, input logic [7:0] d);
        exp_t e;
        e.dv = edv;
        e.pe = epe;
        e.fe = efe;
        if (edv) last_good = d;
        e.pd = last_good;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx7 = v;
        else     rx_in = v;
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        drive(sel, v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input int p, input int dw, input logic [8:0] data,
                              input logic pen, input logic ptyp, input logic s2, input logic flip,
                              input int stop_bad, input int spike_bit);
        logic par;
        hold(sel, 1'b0, p);
        for (int i = 0; i < dw; i++) begin
            if (i == spike_bit) begin
                // one-cycle spike landing on the middle of the three samples
                hold(sel, data[i], p / 2 - 1);
                hold(sel, ~data[i], 1);
                hold(sel, data[i], p - p / 2);
            end else begin
                hold(sel, data[i], p);
            end
        end
        if (pen) begin
            par = ptyp ? ~^data : ^data;
            hold(sel, par ^ flip, p);
        end
        hold(sel, stop_bad != 1, p);
        if (s2) hold(sel, stop_bad != 2, p);
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("result_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            presc  p   pen pt s2 data   flip sb  dv pe fe
        vecs[0] = '{6'd8,  8,  0, 0, 0, 8'hA5, 0, 0, 1, 0, 0};
        vecs[1] = '{6'd16, 16, 1, 1, 0, 8'h3C, 1, 0, 0, 1, 0};
        vecs[2] = '{6'd16, 16, 1, 0, 0, 8'h3C, 0, 0, 1, 0, 0};
        vecs[3] = '{6'd32, 32, 0, 0, 1, 8'hC3, 0, 2, 0, 0, 1};
        vecs[4] = '{6'd8,  8,  1, 1, 0, 8'h00, 0, 0, 1, 0, 0};
        vecs[5] = '{6'd12, 8,  0, 0, 0, 8'h96, 0, 0, 1, 0, 0};
        vecs[6] = '{6'd32, 32, 1, 0, 0, 8'h5A, 1, 1, 0, 1, 1};
        vecs[7] = '{6'd16, 16, 0, 0, 1, 8'hFF, 0, 0, 1, 0, 0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p_data", 32'(p_data), 32'd0);
        check("rst_data_valid", 32'(dv), 32'd0);
        check("rst_parity_error", 32'(pe), 32'd0);
        check("rst_framing_error", 32'(fe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        hold(0, 1'b1, 5);

        // Table of single frames; latency counts the RX_IN drop cycle as cycle 1.
        for (int r = 0; r < 8; r++) begin
            presc   = vecs[r].presc;
            par_en  = vecs[r].par_en;
            par_typ = vecs[r].par_typ;
            stop2   = vecs[r].stop2;
            push_exp(vecs[r].exp_dv, vecs[r].exp_pe, vecs[r].exp_fe, vecs[r].data);
            start_cyc = cyc;
            send_frame(0, vecs[r].p, 8, {1'b0, vecs[r].data}, vecs[r].par_en, vecs[r].par_typ,
                       vecs[r].stop2, vecs[r].par_flip, vecs[r].stop_bad, -1);
            rx_in = 1'b1;
            wait_empty(60);
            if (vecs[r].exp_dv)
                check($sformatf("latency_row%0d", r), 32'(last_dv_cyc - start_cyc + 1),
                      32'(3 + vecs[r].p * (10 + int'(vecs[r].par_en) + int'(vecs[r].stop2))));
            check($sformatf("busy_after_row%0d", r), 32'(busy), 32'd0);
            hold(0, 1'b1, 4);
        end

        // Second stop bit low, then line held low: no new frame until high then low again.
        presc = 6'd32; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1, 8'h00);
        send_frame(0, 32, 8, 9'h0E7, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1);
        wait_empty(60);
        busy_seen = 1'b0;
        hold(0, 1'b0, 100);
        check("held_low_busy", 32'(busy_seen), 32'd0);
        hold(0, 1'b1, 6);
        presc = 6'd8; stop2 = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0, 8'h5A);
        send_frame(0, 8, 8, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        rx_in = 1'b1;
        wait_empty(60);

        // Short low glitch on the idle line at P=16.
        presc = 6'd16;
        hold(0, 1'b1, 4);
        hold(0, 1'b0, 4);
        rx_in = 1'b1;
        check("glitch_busy_high", 32'(busy), 32'd1);
        for (int k = 0; k < 40 && busy; k++) begin
            @(posedge clk);
            #1;
        end
        check("glitch_busy_low", 32'(busy), 32'd0);
        hold(0, 1'b1, 10);

        // Back-to-back frames at P=8, the first with a one-sample spike in data bit 3.
        presc = 6'd8;
        push_exp(1'b1, 1'b0, 1'b0, 8'h55);
        push_exp(1'b1, 1'b0, 1'b0, 8'hFF);
        send_frame(0, 8, 8, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        send_frame(0, 8, 8, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        rx_in = 1'b1;
        wait_empty(60);
        hold(0, 1'b1, 6);

        // Reset in the middle of the data bits aborts silently, then a clean 0x81.
        hold(0, 1'b0, 8);
        hold(0, 1'b1, 8);
        hold(0, 1'b0, 8);
        hold(0, 1'b1, 4);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_p_data", 32'(p_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        last_good = 8'h00;
        hold(0, 1'b1, 10);
        push_exp(1'b1, 1'b0, 1'b0, 8'h81);
        send_frame(0, 8, 8, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        rx_in = 1'b1;
        wait_empty(60);

        // Seven-bit build.
        send_frame(1, 8, 7, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        rx7 = 1'b1;
        for (int k = 0; k < 60 && dv7_cnt == 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("dw7_valid_count", 32'(dv7_cnt), 32'd1);
        check("dw7_p_data", 32'(last_p7), 32'h7F);
        hold(0, 1'b1, 10);
        check("dw7_errors", 32'(err7_cnt), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
